sb_debug_regfile_target: RTL

- System-bus target (responder) that sits on the same sb_* bus the JTAG debug bridge drives as initiator.
- Holds a small bank of 32-bit debug registers that the debugger can read and write in bursts.
- Decodes a fixed address window and answers single or burst read/write transactions.
- Signals decode failures with an error response; all outputs are registered.

---
 rtl/sb_debug_regfile_target.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sb_debug_regfile_target.sv
// System-bus target holding a bank of 32-bit debug registers.
// Answers single and burst reads/writes in a fixed address window; every output is a flop.
module sb_debug_regfile_target #(
   parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
   parameter int          ADDR_WORDS  = 16,
   parameter int          WAIT_STATES = 0
) (
   input  logic        sb_clock_i,
   input  logic        sb_reset_i,
   input  logic        sb_begin_transaction_i,
   input  logic [31:0] sb_address_data_i,
   input  logic        sb_read_n_write_i,
   input  logic [7:0]  sb_burst_size_i,
   input  logic [3:0]  sb_byte_enables_i,
   input  logic        sb_data_valid_i,
   input  logic        sb_end_transaction_i,
   output logic [31:0] sb_address_data_o,
   output logic        sb_data_valid_o,
   output logic        sb_end_transaction_o,
   output logic        sb_busy_o,
   output logic        sb_error_o
);

   localparam int         IDX_W     = $clog2(ADDR_WORDS);
   localparam int         TAG_LSB   = 2 + IDX_W;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {IDLE, WRITE, RWAIT, READ, REND, ERR_R, ERR_W} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [8:0]       remaining, remaining_nxt;
   logic [3:0]       lanes, lanes_nxt;
   logic [3:0]       wait_cnt, wait_cnt_nxt;
   logic [31:0]      data_nxt;
   logic             valid_nxt, end_nxt, busy_nxt, error_nxt;
   logic             wr_en;
   logic [31:0]      regs [ADDR_WORDS];

   logic             hit;
   logic [IDX_W-1:0] addr_idx;
   logic [8:0]       beats_req;

   assign hit       = (sb_address_data_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign addr_idx  = sb_address_data_i[TAG_LSB-1:2];
   assign beats_req = {1'b0, sb_burst_size_i} + 9'd1;

   // Outputs are computed one cycle ahead so they can be registered with the state.
   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      remaining_nxt = remaining;
      lanes_nxt     = lanes;
      wait_cnt_nxt  = wait_cnt;
      data_nxt      = '0;
      valid_nxt     = 1'b0;
      end_nxt       = 1'b0;
      busy_nxt      = 1'b0;
      error_nxt     = 1'b0;
      wr_en         = 1'b0;
      case (state)
         IDLE: begin
            if (sb_begin_transaction_i) begin
               lanes_nxt = sb_byte_enables_i;
               if (!hit) begin
                  error_nxt = 1'b1;
                  if (sb_read_n_write_i) begin
                     state_nxt = ERR_R;
                     end_nxt   = 1'b1;
                  end else begin
                     state_nxt = ERR_W;
                  end
               end else if (!sb_read_n_write_i) begin
                  state_nxt     = WRITE;
                  idx_nxt       = addr_idx;
                  remaining_nxt = beats_req;
               end else if (WAIT_STATES > 0) begin
                  state_nxt     = RWAIT;
                  busy_nxt      = 1'b1;
                  wait_cnt_nxt  = WAIT_LOAD;
                  idx_nxt       = addr_idx;
                  remaining_nxt = beats_req;
               end else begin
                  state_nxt     = READ;
                  valid_nxt     = 1'b1;
                  data_nxt      = regs[addr_idx];
                  idx_nxt       = addr_idx + IDX_W'(1);
                  remaining_nxt = beats_req - 9'd1;
               end
            end
         end
         WRITE: begin
            if (sb_data_valid_i && (remaining != 9'd0)) begin
               wr_en         = 1'b1;
               idx_nxt       = idx + IDX_W'(1);
               remaining_nxt = remaining - 9'd1;
            end
            if (sb_end_transaction_i) begin
               state_nxt = IDLE;
            end
         end
         RWAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt     = READ;
               valid_nxt     = 1'b1;
               data_nxt      = regs[idx];
               idx_nxt       = idx + IDX_W'(1);
               remaining_nxt = remaining - 9'd1;
            end else begin
               busy_nxt     = 1'b1;
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         READ: begin
            // remaining counts beats not yet placed on the bus
            if (remaining == 9'd0) begin
               state_nxt = REND;
               end_nxt   = 1'b1;
            end else begin
               valid_nxt     = 1'b1;
               data_nxt      = regs[idx];
               idx_nxt       = idx + IDX_W'(1);
               remaining_nxt = remaining - 9'd1;
            end
         end
         REND: begin
            state_nxt = IDLE;
         end
         ERR_R: begin
            state_nxt = IDLE;
         end
         ERR_W: begin
            if (sb_end_transaction_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge sb_clock_i or posedge sb_reset_i) begin
      if (sb_reset_i) begin
         state                <= IDLE;
         idx                  <= '0;
         remaining            <= '0;
         lanes                <= '0;
         wait_cnt             <= '0;
         sb_address_data_o    <= '0;
         sb_data_valid_o      <= 1'b0;
         sb_end_transaction_o <= 1'b0;
         sb_busy_o            <= 1'b0;
         sb_error_o           <= 1'b0;
      end else begin
         state                <= state_nxt;
         idx                  <= idx_nxt;
         remaining            <= remaining_nxt;
         lanes                <= lanes_nxt;
         wait_cnt             <= wait_cnt_nxt;
         sb_address_data_o    <= data_nxt;
         sb_data_valid_o      <= valid_nxt;
         sb_end_transaction_o <= end_nxt;
         sb_busy_o            <= busy_nxt;
         sb_error_o           <= error_nxt;
      end
   end

   // Write beats merge only the enabled byte lanes into the addressed register.
   always_ff @(posedge sb_clock_i or posedge sb_reset_i) begin
      if (sb_reset_i) begin
         for (int i = 0; i < ADDR_WORDS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes[b]) begin
               regs[idx][8*b +: 8] <= sb_address_data_i[8*b +: 8];
            end
         end
      end
   end

endmodule
